// File: rtl/gamepad_pmod_rx.sv
// TT Gamepad PMOD receiver: synchronises the latch/clk/data lines, deserialises a
// two-controller frame, commits it on latch rise and derives a single new-move event.
module gamepad_pmod_rx #(
  parameter int unsigned NUM_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pmod_latch,
  input  logic                pmod_clk,
  input  logic                pmod_data,
  output logic [NUM_BITS-1:0] buttons,
  output logic [1:0]          present,
  output logic                frame_valid,
  output logic                frame_err,
  output logic                move_valid,
  output logic [1:0]          move_dir
);

  localparam int unsigned HALF = NUM_BITS / 2;
  localparam int unsigned CW   = $clog2(NUM_BITS + 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_BITS);
  localparam logic [CW-1:0] SAT_CNT  = CW'(NUM_BITS + 1);

  logic [1:0]          latch_sync;
  logic [1:0]          clk_sync;
  logic [1:0]          data_sync;
  logic                latch_hist;
  logic                clk_hist;
  logic                latch_rise;
  logic                clk_rise;
  logic [NUM_BITS-1:0] shreg;
  logic [CW-1:0]       bitcnt;
  logic [3:0]          dpad_prev;

  logic                p0;
  logic                p1;
  logic [3:0]          dpad;
  logic [3:0]          newp;
  logic [1:0]          dir_next;

  assign latch_rise = latch_sync[1] & ~latch_hist;
  assign clk_rise   = clk_sync[1] & ~clk_hist;

  // Presence and d-pad come from the frame about to be committed, so the move
  // event lands in the same cycle as frame_valid.
  always_comb begin
    p0       = (shreg[NUM_BITS-1:HALF] != '1);
    p1       = (shreg[HALF-1:0] != '1);
    dpad     = ({4{p0}} & shreg[HALF+7:HALF+4]) | ({4{p1}} & shreg[7:4]);
    newp     = dpad & ~dpad_prev;
    dir_next = 2'd3;
    if (newp[3])      dir_next = 2'd0;
    else if (newp[2]) dir_next = 2'd1;
    else if (newp[1]) dir_next = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_sync  <= '0;
      clk_sync    <= '0;
      data_sync   <= '0;
      latch_hist  <= 1'b0;
      clk_hist    <= 1'b0;
      shreg       <= '0;
      bitcnt      <= '0;
      dpad_prev   <= '0;
      buttons     <= '0;
      present     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      move_valid  <= 1'b0;
      move_dir    <= '0;
    end else begin
      latch_sync  <= {latch_sync[0], pmod_latch};
      clk_sync    <= {clk_sync[0], pmod_clk};
      data_sync   <= {data_sync[0], pmod_data};
      latch_hist  <= latch_sync[1];
      clk_hist    <= clk_sync[1];
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      move_valid  <= 1'b0;

      // Latch takes precedence: a coincident clk rise is dropped.
      if (latch_rise) begin
        bitcnt <= '0;
        if (bitcnt == FULL_CNT) begin
          buttons     <= shreg;
          present     <= {p1, p0};
          frame_valid <= 1'b1;
          dpad_prev   <= dpad;
          if (newp != 4'b0000) begin
            move_valid <= 1'b1;
            move_dir   <= dir_next;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else if (clk_rise) begin
        shreg <= {shreg[NUM_BITS-2:0], data_sync[1]};
        if (bitcnt != SAT_CNT)
          bitcnt <= bitcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Directed bench for gamepad_pmod_rx: table of frames with hand-computed results,
// plus sequences for mid-frame reset and coincident latch/clk edges.
module tb_gamepad_pmod_rx;

  logic        clk;
  logic        rst;
  logic        pmod_latch;
  logic        pmod_clk;
  logic        pmod_data;
  logic [23:0] buttons;
  logic [1:0]  present;
  logic        frame_valid;
  logic        frame_err;
  logic        move_valid;
  logic [1:0]  move_dir;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned fv_cnt   = 0;
  int unsigned fe_cnt   = 0;
  int unsigned mv_cnt   = 0;
  int unsigned fv0, fe0, mv0;

  gamepad_pmod_rx #(.NUM_BITS(24)) dut (
    .clk(clk), .rst(rst),
    .pmod_latch(pmod_latch), .pmod_clk(pmod_clk), .pmod_data(pmod_data),
    .buttons(buttons), .present(present),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .move_valid(move_valid), .move_dir(move_dir)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Count high cycles of each pulse so a stretched pulse shows up as >1.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (move_valid)  mv_cnt <= mv_cnt + 1;
  end

  typedef struct {
    logic [23:0] frame;
    int unsigned nbits;
    logic [23:0] exp_buttons;
    logic [1:0]  exp_present;
    int unsigned exp_fv;
    int unsigned exp_fe;
    int unsigned exp_mv;
    logic [1:0]  exp_dir;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [23:0] frame, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      pmod_data = (i < 24) ? frame[23 - i] : 1'b0;
      cycles(4);
      pmod_clk = 1'b1;
      cycles(4);
      pmod_clk = 1'b0;
      cycles(4);
    end
  endtask

  task automatic do_latch();
    pmod_latch = 1'b1;
    cycles(4);
    pmod_latch = 1'b0;
    cycles(8);
  endtask

  task automatic snap();
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    mv0 = mv_cnt;
  endtask

  task automatic check_frame(input string tag, input logic [23:0] eb, input logic [1:0] ep,
                             input int unsigned efv, input int unsigned efe,
                             input int unsigned emv, input logic [1:0] ed);
    chk({tag, ".buttons"},     32'(buttons), 32'(eb));
    chk({tag, ".present"},     32'(present), 32'(ep));
    chk({tag, ".frame_valid"}, fv_cnt - fv0, efv);
    chk({tag, ".frame_err"},   fe_cnt - fe0, efe);
    chk({tag, ".move_valid"},  mv_cnt - mv0, emv);
    chk({tag, ".move_dir"},    32'(move_dir), 32'(ed));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".buttons"},  32'(buttons), 32'h0);
    chk({tag, ".present"},  32'(present), 32'h0);
    chk({tag, ".move_dir"}, 32'(move_dir), 32'h0);
    chk({tag, ".pulses"},   32'({frame_valid, frame_err, move_valid}), 32'h0);
  endtask

  initial begin
    //         frame      bits  buttons     pres   fv fe mv dir
    vecs[0] = '{24'h080FFF, 24, 24'h080FFF, 2'b01, 1, 0, 1, 2'd0}; // Up, ctrl1 absent
    vecs[1] = '{24'h080FFF, 24, 24'h080FFF, 2'b01, 1, 0, 0, 2'd0}; // held: no move
    vecs[2] = '{24'h0C0FFF, 24, 24'h0C0FFF, 2'b01, 1, 0, 1, 2'd1}; // only Down new
    vecs[3] = '{24'h123456, 23, 24'h0C0FFF, 2'b01, 0, 1, 0, 2'd1}; // short frame
    vecs[4] = '{24'h654321, 25, 24'h0C0FFF, 2'b01, 0, 1, 0, 2'd1}; // long frame
    vecs[5] = '{24'h030000, 24, 24'h030000, 2'b11, 1, 0, 1, 2'd2}; // Left beats Right
    vecs[6] = '{24'h000FFF, 24, 24'h000FFF, 2'b01, 1, 0, 0, 2'd2}; // nothing pressed
    vecs[7] = '{24'hFFF010, 24, 24'hFFF010, 2'b10, 1, 0, 1, 2'd3}; // ctrl1 Right
    vecs[8] = '{24'hFFFFFF, 24, 24'hFFFFFF, 2'b00, 1, 0, 0, 2'd3}; // none present

    rst        = 1'b1;
    pmod_latch = 1'b0;
    pmod_clk   = 1'b0;
    pmod_data  = 1'b0;
    cycles(4);
    check_zero("reset");
    rst = 1'b0;
    cycles(4);

    for (int i = 0; i < 9; i++) begin
      snap();
      shift_bits(vecs[i].frame, vecs[i].nbits);
      do_latch();
      check_frame($sformatf("vec%0d", i), vecs[i].exp_buttons, vecs[i].exp_present,
                  vecs[i].exp_fv, vecs[i].exp_fe, vecs[i].exp_mv, vecs[i].exp_dir);
    end

    // Reset after 12 bits, then a full frame must be accepted from scratch.
    shift_bits(24'hABCDEF, 12);
    rst = 1'b1;
    cycles(3);
    check_zero("midrst");
    rst = 1'b0;
    cycles(4);
    snap();
    shift_bits(24'h040FFF, 24);
    do_latch();
    check_frame("postrst", 24'h040FFF, 2'b01, 1, 0, 1, 2'd1);

    // Latch and an extra clk rise on the same edge after 24 bits.
    snap();
    shift_bits(24'h020FFF, 24);
    pmod_data  = 1'b1;
    cycles(4);
    pmod_latch = 1'b1;
    pmod_clk   = 1'b1;
    cycles(4);
    pmod_latch = 1'b0;
    pmod_clk   = 1'b0;
    cycles(8);
    check_frame("coinc", 24'h020FFF, 2'b01, 1, 0, 1, 2'd2);

    // The ignored clk must not have counted: exactly 24 more bits commit cleanly.
    snap();
    shift_bits(24'h010FFF, 24);
    do_latch();
    check_frame("restart", 24'h010FFF, 2'b01, 1, 0, 1, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
